// File: rtl/vend_controller_pkg.sv
// Shared definitions for the vending datapath: coin encoding, cents width, controller state encoding.
// Coin indices and values are also used by the downstream change maker.
package vend_controller_pkg;

  localparam int CENTS_W = 9;
  localparam int COIN_W  = 5;

  localparam int COIN_DOLLAR  = 4;
  localparam int COIN_HALF    = 3;
  localparam int COIN_QUARTER = 2;
  localparam int COIN_DIME    = 1;
  localparam int COIN_NICKEL  = 0;

  localparam logic [CENTS_W-1:0] CENTS_DOLLAR  = 9'd100;
  localparam logic [CENTS_W-1:0] CENTS_HALF    = 9'd50;
  localparam logic [CENTS_W-1:0] CENTS_QUARTER = 9'd25;
  localparam logic [CENTS_W-1:0] CENTS_DIME    = 9'd10;
  localparam logic [CENTS_W-1:0] CENTS_NICKEL  = 9'd5;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CREDIT    = 2'd1;
  localparam logic [1:0] ST_CHG_START = 2'd2;
  localparam logic [1:0] ST_CHG_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    CREDIT    = ST_CREDIT,
    CHG_START = ST_CHG_START,
    CHG_WAIT  = ST_CHG_WAIT
  } state_t;

endpackage

// File: rtl/vend_controller_coin_value_decode.sv
// Combinational one-hot coin to cents decode; invalid flags any non-zero, non-one-hot pattern.
// Zero input decodes to 0 cents and is not invalid.
module coin_value_decode
  import vend_controller_pkg::*;
(
  input  logic [4:0] coin,
  output logic [8:0] value,
  output logic       invalid
);

  always_comb begin
    value   = '0;
    invalid = 1'b0;
    if ((coin != '0) && !$onehot(coin)) begin
      invalid = 1'b1;
    end else if (coin[COIN_DOLLAR]) begin
      value = CENTS_DOLLAR;
    end else if (coin[COIN_HALF]) begin
      value = CENTS_HALF;
    end else if (coin[COIN_QUARTER]) begin
      value = CENTS_QUARTER;
    end else if (coin[COIN_DIME]) begin
      value = CENTS_DIME;
    end else if (coin[COIN_NICKEL]) begin
      value = CENTS_NICKEL;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Vending front end: coin credit, item select, cancel/refund, and change hand-off to the change maker.
// All outputs registered; each response appears one cycle after the input causing it.
module vend_controller
  import vend_controller_pkg::*;
#(
  parameter int PRICE0     = 65,
  parameter int PRICE1     = 125,
  parameter int PRICE2     = 150,
  parameter int PRICE3     = 35,
  parameter int MAX_CREDIT = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] coin_in,
  input  logic       select_valid,
  input  logic [1:0] select_id,
  input  logic       cancel,
  input  logic       cm_done,
  output logic       cm_start,
  output logic [8:0] change_amt,
  output logic [8:0] credit,
  output logic       vend_valid,
  output logic [1:0] vend_id,
  output logic       coin_reject,
  output logic       err_insufficient,
  output logic       busy
);

  localparam logic [CENTS_W-1:0] P0    = CENTS_W'(PRICE0);
  localparam logic [CENTS_W-1:0] P1    = CENTS_W'(PRICE1);
  localparam logic [CENTS_W-1:0] P2    = CENTS_W'(PRICE2);
  localparam logic [CENTS_W-1:0] P3    = CENTS_W'(PRICE3);
  localparam logic [CENTS_W:0]   MAX_C = (CENTS_W+1)'(MAX_CREDIT);

  state_t       state, state_n;
  logic [8:0]   credit_n;
  logic [8:0]   change_n;
  logic [1:0]   vend_id_n;
  logic         vend_valid_n;
  logic         coin_reject_n;
  logic         err_n;
  logic         cm_start_n;
  logic         busy_n;

  logic [8:0]   coin_value;
  logic         coin_invalid;
  logic         coin_present;
  logic [9:0]   coin_sum;
  logic         coin_fits;
  logic [8:0]   price;

  coin_value_decode u_coin_decode (
    .coin    (coin_in),
    .value   (coin_value),
    .invalid (coin_invalid)
  );

  assign coin_present = (coin_in != '0);
  // One extra bit so credit + coin can never wrap before the limit check.
  assign coin_sum     = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits    = !coin_invalid && (coin_sum <= MAX_C);

  always_comb begin
    price = P0;
    case (select_id)
      2'd0:    price = P0;
      2'd1:    price = P1;
      2'd2:    price = P2;
      default: price = P3;
    endcase
  end

  always_comb begin
    state_n       = state;
    credit_n      = credit;
    change_n      = change_amt;
    vend_id_n     = vend_id;
    vend_valid_n  = 1'b0;
    coin_reject_n = 1'b0;
    err_n         = 1'b0;

    case (state)
      IDLE, CREDIT: begin
        if (cancel) begin
          // Cancel consumes the cycle even with no credit, so a coin alongside it is returned.
          if (credit != '0) begin
            change_n = credit;
            state_n  = CHG_START;
          end
          coin_reject_n = coin_present;
        end else if (select_valid) begin
          if (credit >= price) begin
            vend_valid_n = 1'b1;
            vend_id_n    = select_id;
            change_n     = credit - price;
            if (credit == price) begin
              credit_n = '0;
              state_n  = IDLE;
            end else begin
              state_n  = CHG_START;
            end
          end else begin
            err_n = 1'b1;
          end
          coin_reject_n = coin_present;
        end else if (coin_present) begin
          if (coin_fits) begin
            credit_n = coin_sum[8:0];
            state_n  = CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end
      end

      CHG_START: begin
        credit_n      = '0;
        state_n       = CHG_WAIT;
        coin_reject_n = coin_present;
      end

      CHG_WAIT: begin
        coin_reject_n = coin_present;
        if (cm_done) begin
          change_n = '0;
          state_n  = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    cm_start_n = (state_n == CHG_START);
    busy_n     = (state_n == CHG_START) || (state_n == CHG_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      credit           <= '0;
      change_amt       <= '0;
      vend_id          <= '0;
      vend_valid       <= 1'b0;
      coin_reject      <= 1'b0;
      err_insufficient <= 1'b0;
      cm_start         <= 1'b0;
      busy             <= 1'b0;
    end else begin
      state            <= state_n;
      credit           <= credit_n;
      change_amt       <= change_n;
      vend_id          <= vend_id_n;
      vend_valid       <= vend_valid_n;
      coin_reject      <= coin_reject_n;
      err_insufficient <= err_n;
      cm_start         <= cm_start_n;
      busy             <= busy_n;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scenario bench for vend_controller: per-cycle stimulus with hand-derived expected outputs
// queued in a scoreboard and compared one cycle later.
module tb_vend_controller;

  logic       clk;
  logic       reset;
  logic [4:0] coin_in;
  logic       select_valid;
  logic [1:0] select_id;
  logic       cancel;
  logic       cm_done;
  logic       cm_start;
  logic [8:0] change_amt;
  logic [8:0] credit;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       coin_reject;
  logic       err_insufficient;
  logic       busy;

  vend_controller dut (
    .clk              (clk),
    .reset            (reset),
    .coin_in          (coin_in),
    .select_valid     (select_valid),
    .select_id        (select_id),
    .cancel           (cancel),
    .cm_done          (cm_done),
    .cm_start         (cm_start),
    .change_amt       (change_amt),
    .credit           (credit),
    .vend_valid       (vend_valid),
    .vend_id          (vend_id),
    .coin_reject      (coin_reject),
    .err_insufficient (err_insufficient),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] coin;
    logic       sel;
    logic [1:0] id;
    logic       cncl;
    logic       done;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic       cms;
    logic [8:0] chg;
    logic [8:0] cr;
    logic       vv;
    logic [1:0] vid;
    logic       rej;
    logic       err;
    logic       bsy;
  } obs_t;

  stim_t stim_q[$];
  obs_t  sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic stim_t st(input logic [4:0] coin, input logic sel, input int id,
                               input logic cncl, input logic done, input logic rst);
    stim_t s;
    s.coin = coin;
    s.sel  = sel;
    s.id   = id[1:0];
    s.cncl = cncl;
    s.done = done;
    s.rst  = rst;
    return s;
  endfunction

  function automatic stim_t idle();
    return st(5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic obs_t ex(input logic cms, input int chg, input int cr, input logic vv,
                              input int vid, input logic rej, input logic err, input logic bsy);
    obs_t o;
    o.cms = cms;
    o.chg = chg[8:0];
    o.cr  = cr[8:0];
    o.vv  = vv;
    o.vid = vid[1:0];
    o.rej = rej;
    o.err = err;
    o.bsy = bsy;
    return o;
  endfunction

  function automatic string show(input obs_t o);
    return $sformatf("cm_start=%b change=%0d credit=%0d vend=%b id=%0d reject=%b err=%b busy=%b",
                     o.cms, o.chg, o.cr, o.vv, o.vid, o.rej, o.err, o.bsy);
  endfunction

  task automatic add(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    sb.push_back(e);
  endtask

  // Drives the next queued stimulus for one cycle and samples outputs just after the edge.
  task automatic run_one(output obs_t got);
    stim_t s;
    s = stim_q.pop_front();
    @(negedge clk);
    coin_in      = s.coin;
    select_valid = s.sel;
    select_id    = s.id;
    cancel       = s.cncl;
    cm_done      = s.done;
    reset        = s.rst;
    @(posedge clk);
    #1;
    got.cms = cm_start;
    got.chg = change_amt;
    got.cr  = credit;
    got.vv  = vend_valid;
    got.vid = vend_id;
    got.rej = coin_reject;
    got.err = err_insufficient;
    got.bsy = busy;
  endtask

  task automatic test_reset();
    obs_t got, e;
    int step = 0;
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b1), ex(0, 0, 0, 0, 0, 0, 0, 0));
    add(st(5'b00100, 1'b1, 2, 1'b1, 1'b1, 1'b1), ex(0, 0, 0, 0, 0, 0, 0, 0));
    add(idle(),                                   ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  task automatic test_exact_vend();
    obs_t got, e;
    int step = 0;
    add(st(5'b00100, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 25, 0, 0, 0, 0, 0));
    add(st(5'b00100, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 50, 0, 0, 0, 0, 0));
    add(st(5'b00010, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 60, 0, 0, 0, 0, 0));
    add(st(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 65, 0, 0, 0, 0, 0));
    add(st(5'b00000, 1'b1, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 0, 1, 0, 0, 0, 0));
    // Back in IDLE: any select is insufficient.
    add(st(5'b00000, 1'b1, 3, 1'b0, 1'b0, 1'b0), ex(0, 0, 0, 0, 0, 0, 1, 0));
    add(idle(),                                   ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL exact_vend step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  task automatic test_change_wait();
    obs_t got, e;
    int step = 0;
    add(st(5'b10000, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 100, 0, 0, 0, 0, 0));
    add(st(5'b00100, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 125, 0, 0, 0, 0, 0));
    add(st(5'b00000, 1'b1, 3, 1'b0, 1'b0, 1'b0), ex(1, 90, 125, 1, 3, 0, 0, 1));
    for (int i = 0; i < 10; i++) add(idle(), ex(0, 90, 0, 0, 3, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 0, 0, 0, 3, 0, 0, 0));
    add(idle(),                                   ex(0, 0, 0, 0, 3, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL change_wait step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  task automatic test_insufficient_cancel();
    obs_t got, e;
    int step = 0;
    add(st(5'b01000, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 50, 0, 3, 0, 0, 0));
    add(st(5'b00000, 1'b1, 2, 1'b0, 1'b0, 1'b0), ex(0, 0, 50, 0, 3, 0, 1, 0));
    add(st(5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0), ex(1, 50, 50, 0, 3, 0, 0, 1));
    add(idle(),                                   ex(0, 50, 0, 0, 3, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 0, 0, 0, 3, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL insufficient_cancel step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  task automatic test_limits();
    obs_t got, e;
    int step = 0;
    for (int i = 1; i <= 5; i++) add(st(5'b10000, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 100 * i, 0, 3, 0, 0, 0));
    add(st(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 500, 0, 3, 1, 0, 0));
    add(st(5'b00011, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 500, 0, 3, 1, 0, 0));
    add(st(5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0), ex(1, 500, 500, 0, 3, 0, 0, 1));
    // cm_done arriving in CHG_START must not end the hand-off.
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 500, 0, 0, 3, 0, 0, 1));
    add(idle(),                                   ex(0, 500, 0, 0, 3, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 0, 0, 0, 3, 0, 0, 0));
    add(st(5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0), ex(0, 0, 0, 0, 3, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL limits step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t got, e;
    int step = 0;
    add(st(5'b00100, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 25, 0, 3, 0, 0, 0));
    add(st(5'b00010, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 35, 0, 3, 0, 0, 0));
    add(st(5'b00100, 1'b1, 3, 1'b0, 1'b0, 1'b0), ex(0, 0, 0, 1, 3, 1, 0, 0));
    add(st(5'b10000, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 100, 0, 3, 0, 0, 0));
    add(st(5'b00000, 1'b1, 0, 1'b0, 1'b0, 1'b0), ex(1, 35, 100, 1, 0, 0, 0, 1));
    add(st(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 35, 0, 0, 0, 1, 0, 1));
    add(st(5'b00100, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 35, 0, 0, 0, 1, 0, 1));
    add(st(5'b00000, 1'b1, 1, 1'b0, 1'b0, 1'b0), ex(0, 35, 0, 0, 0, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0), ex(0, 35, 0, 0, 0, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  task automatic test_reset_midop();
    obs_t got, e;
    int step = 0;
    add(st(5'b10000, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 100, 0, 0, 0, 0, 0));
    add(st(5'b00000, 1'b1, 3, 1'b0, 1'b0, 1'b0), ex(1, 65, 100, 1, 3, 0, 0, 1));
    add(idle(),                                   ex(0, 65, 0, 0, 3, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b0, 1'b1), ex(0, 0, 0, 0, 0, 0, 0, 0));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 0, 0, 0, 0, 0, 0, 0));
    add(idle(),                                   ex(0, 0, 0, 0, 0, 0, 0, 0));
    add(st(5'b00001, 1'b0, 0, 1'b0, 1'b0, 1'b0), ex(0, 0, 5, 0, 0, 0, 0, 0));
    add(st(5'b00000, 1'b0, 0, 1'b1, 1'b0, 1'b0), ex(1, 5, 5, 0, 0, 0, 0, 1));
    add(idle(),                                   ex(0, 5, 0, 0, 0, 0, 0, 1));
    add(st(5'b00000, 1'b0, 0, 1'b0, 1'b1, 1'b0), ex(0, 0, 0, 0, 0, 0, 0, 0));
    while (stim_q.size() != 0) begin
      run_one(got);
      e = sb.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_midop step %0d: got %s want %s", step, show(got), show(e));
      end
      step++;
    end
  endtask

  initial begin
    reset        = 1'b0;
    coin_in      = '0;
    select_valid = 1'b0;
    select_id    = '0;
    cancel       = 1'b0;
    cm_done      = 1'b0;
    #2 reset = 1'b1;
    test_reset();
    test_exact_vend();
    test_change_wait();
    test_insufficient_cancel();
    test_limits();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
